// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the next-PC sequencer: widths, reset PC, FSM states
// and the branch-offset sign extension.
package pc_sequencer_pkg;

    localparam int unsigned        PC_WIDTH         = 30;
    localparam int unsigned        IMM_WIDTH        = 16;
    localparam int unsigned        JT_WIDTH         = 26;
    localparam logic [PC_WIDTH-1:0] RESET_PC_DEFAULT = 30'h00400020;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        INCR   = 2'd1,
        BRANCH = 2'd2,
        UPDATE = 2'd3
    } state_t;

    // Signed word offset widened to PC width.
    function automatic logic [PC_WIDTH-1:0] sext_imm(input logic [IMM_WIDTH-1:0] imm);
        return {{(PC_WIDTH - IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Step-request / PC-output bundle between decode and the sequencer.
interface pc_sequencer_if;
    import pc_sequencer_pkg::*;

    logic                  step_valid;
    logic                  step_ready;
    logic                  br_taken;
    logic [IMM_WIDTH-1:0]  br_imm;
    logic                  jmp;
    logic [JT_WIDTH-1:0]   jmp_target;
    logic [PC_WIDTH-1:0]   pc;
    logic                  pc_valid;

    // Decode side: issues steps, observes the PC.
    modport master (
        output step_valid, br_taken, br_imm, jmp, jmp_target,
        input  step_ready, pc, pc_valid
    );

    // Sequencer side.
    modport slave (
        input  step_valid, br_taken, br_imm, jmp, jmp_target,
        output step_ready, pc, pc_valid
    );

endinterface

// File: rtl/full_adder_30.sv
// 30-bit adder with carry-in; carry-out is dropped so sums wrap mod 2^30.
module full_adder_30 (
    input  logic [29:0] A,
    input  logic [29:0] B,
    input  logic        c,
    output logic [29:0] out
);

    assign out = A + B + {29'b0, c};

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle next-PC controller. One shared adder computes PC+1 and then,
// for taken branches, PC+1+sext(imm). Jumps bypass the adder entirely.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned          PC_W     = PC_WIDTH,
    parameter int unsigned          IMM_W    = IMM_WIDTH,
    parameter int unsigned          JT_W     = JT_WIDTH,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = RESET_PC_DEFAULT
) (
    input logic           clk,
    input logic           rst,
    pc_sequencer_if.slave bus
);

    state_t            state_q;
    logic [PC_W-1:0]   pc_q;
    logic [PC_W-1:0]   pc1_q;
    logic [PC_W-1:0]   next_q;
    logic              br_taken_q;
    logic [IMM_W-1:0]  br_imm_q;
    logic              pc_valid_q;
    logic              ready_q;

    logic [PC_W-1:0]   add_a_d;
    logic [PC_W-1:0]   add_b_d;
    logic              add_c_d;
    logic [PC_W-1:0]   add_sum;

    // Adder operand select: PC+1 in INCR, PC1+offset in BRANCH, idle otherwise.
    always_comb begin
        add_a_d = pc_q;
        add_b_d = '0;
        add_c_d = 1'b0;
        case (state_q)
            INCR: begin
                add_c_d = 1'b1;
            end
            BRANCH: begin
                add_a_d = pc1_q;
                add_b_d = sext_imm(br_imm_q);
            end
            default: ;
        endcase
    end

    full_adder_30 u_adder (
        .A   (add_a_d),
        .B   (add_b_d),
        .c   (add_c_d),
        .out (add_sum)
    );

    // Step FSM with registered handshake and PC outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            pc1_q      <= '0;
            next_q     <= '0;
            br_taken_q <= 1'b0;
            br_imm_q   <= '0;
            pc_valid_q <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            pc_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.step_valid && ready_q) begin
                        ready_q    <= 1'b0;
                        br_taken_q <= bus.br_taken;
                        br_imm_q   <= bus.br_imm;
                        if (bus.jmp) begin
                            next_q  <= {pc_q[PC_W-1:JT_W], bus.jmp_target};
                            state_q <= UPDATE;
                        end else begin
                            state_q <= INCR;
                        end
                    end
                end
                INCR: begin
                    pc1_q <= add_sum;
                    if (br_taken_q) begin
                        state_q <= BRANCH;
                    end else begin
                        next_q  <= add_sum;
                        state_q <= UPDATE;
                    end
                end
                BRANCH: begin
                    next_q  <= add_sum;
                    state_q <= UPDATE;
                end
                UPDATE: begin
                    pc_q       <= next_q;
                    pc_valid_q <= 1'b1;
                    ready_q    <= 1'b1;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.step_ready = ready_q;
    assign bus.pc         = pc_q;
    assign bus.pc_valid   = pc_valid_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a default-reset instance driven with
// directed and random steps, plus a top-of-range instance for wrap-around.
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_sequencer_if ifa ();
    pc_sequencer_if ifb ();

    pc_sequencer u_dut (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    pc_sequencer #(.RESET_PC(30'h3FFFFFFF)) u_top (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    typedef struct {
        logic [29:0] pc;
        longint      cyc;
    } exp_t;

    exp_t        sb[$];
    longint      cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    logic [29:0] model_pc;
    logic        prev_valid = 1'b0;
    logic [29:0] last_pc = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference next-PC from the architectural rules, using plain integer arithmetic.
    function automatic logic [29:0] ref_next(input logic [29:0] cur, input logic br,
                                             input logic [15:0] imm, input logic j,
                                             input logic [25:0] tgt);
        longint s;
        if (j) return (cur & 30'h3C000000) | {4'b0, tgt};
        s = longint'(cur) + 1;
        if (br) s = s + longint'($signed(imm));
        return s[29:0];
    endfunction

    // Monitor: pop an expectation on every pc_valid pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_valid = 1'b0;
            last_pc    = ifa.pc;
        end else begin
            if (ifa.pc_valid && prev_valid) check("pc_valid_width", 64'd1, 64'd0);
            if (!ifa.pc_valid && ifa.pc !== last_pc) check("pc_changed_silently", ifa.pc, last_pc);
            if (ifa.pc_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_pc_valid", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("pc", ifa.pc, e.pc);
                    check("latency_cycle", cyc, e.cyc);
                end
            end
            prev_valid = ifa.pc_valid;
            last_pc    = ifa.pc;
        end
    end

    task automatic do_step(input logic br, input logic [15:0] imm, input logic j,
                           input logic [25:0] tgt, input bit junk);
        int unsigned w = 0;
        exp_t e;
        while (!ifa.step_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!ifa.step_ready) begin
            check("ready_timeout", 64'd0, 64'd1);
            return;
        end
        ifa.step_valid = 1'b1;
        ifa.br_taken   = br;
        ifa.br_imm     = imm;
        ifa.jmp        = j;
        ifa.jmp_target = tgt;
        e.pc  = ref_next(model_pc, br, imm, j, tgt);
        e.cyc = cyc + (j ? 2 : (br ? 4 : 3));
        model_pc = e.pc;
        sb.push_back(e);
        @(negedge clk);
        ifa.step_valid = 1'b0;
        w = 0;
        while (!ifa.step_ready && w < 40) begin
            if (junk) begin
                ifa.step_valid = 1'($urandom_range(0, 1));
                ifa.br_taken   = 1'($urandom);
                ifa.jmp        = 1'($urandom);
                ifa.br_imm     = 16'($urandom);
                ifa.jmp_target = 26'($urandom);
            end
            @(negedge clk);
            w++;
        end
        ifa.step_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned w = 0;
        while (sb.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    task automatic do_reset();
        drain();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_pc = RESET_PC_DEFAULT;
        #1;
        check("reset_pc", ifa.pc, 30'h00400020);
        check("reset_ready", ifa.step_ready, 1'b1);
        check("reset_pc_valid", ifa.pc_valid, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        int unsigned pulses;
        ifa.step_valid = 0; ifa.br_taken = 0; ifa.br_imm = '0; ifa.jmp = 0; ifa.jmp_target = '0;
        ifb.step_valid = 0; ifb.br_taken = 0; ifb.br_imm = '0; ifb.jmp = 0; ifb.jmp_target = '0;
        model_pc = RESET_PC_DEFAULT;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_pc", ifa.pc, 30'h00400020);
        check("reset_ready", ifa.step_ready, 1'b1);
        check("reset_pc_valid", ifa.pc_valid, 1'b0);
        check("top_reset_pc", ifb.pc, 30'h3FFFFFFF);

        // Wrap at the top of the range; requests while busy are dropped.
        @(negedge clk);
        ifb.step_valid = 1'b1;
        @(negedge clk);
        ifb.jmp = 1'b1; ifb.jmp_target = 26'h155;
        @(negedge clk);
        ifb.br_taken = 1'b1;
        @(negedge clk);
        ifb.step_valid = 1'b0;
        check("wrap_pc_valid", ifb.pc_valid, 1'b1);
        check("wrap_pc", ifb.pc, 30'h00000000);
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (ifb.pc_valid) pulses++;
        end
        check("wrap_extra_pulses", pulses, 0);
        check("wrap_pc_hold", ifb.pc, 30'h00000000);

        // Sequential, branch forward/backward, jump-over-branch from reset PC.
        do_step(1'b0, 16'h0000, 1'b0, 26'h0, 1'b0);
        do_reset();
        do_step(1'b1, 16'h4000, 1'b0, 26'h0, 1'b0);
        do_reset();
        do_step(1'b1, 16'hFFE0, 1'b0, 26'h0, 1'b0);
        do_reset();
        do_step(1'b1, 16'h1234, 1'b1, 26'h0000100, 1'b0);
        drain();

        // Randomized steps, back-to-back, with ignored requests while busy.
        for (int i = 0; i < 250; i++) begin
            do_step(1'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0),
                    26'($urandom), 1'($urandom));
        end
        drain();

        // Reset while in BRANCH aborts the step.
        ifa.step_valid = 1'b1; ifa.br_taken = 1'b1; ifa.br_imm = 16'h0100; ifa.jmp = 1'b0;
        @(negedge clk);
        ifa.step_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_pc", ifa.pc, 30'h00400020);
        check("abort_pc_valid", ifa.pc_valid, 1'b0);
        check("abort_ready", ifa.step_ready, 1'b1);
        repeat (2) begin
            @(negedge clk);
            check("abort_pc_valid_hold", ifa.pc_valid, 1'b0);
        end
        rst = 1'b0;
        model_pc = RESET_PC_DEFAULT;
        @(negedge clk);
        do_step(1'b0, 16'h0000, 1'b0, 26'h0, 1'b0);
        drain();
        check("final_pc", ifa.pc, 30'h00400021);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
